// File: rtl/snax_acc_share_arbiter_pkg.sv
// Shared helpers for the accelerator-sharing arbiter. No new types live here;
// accelerator address and hart typedefs stay in snax_snitch_pkg.
package snax_acc_share_arbiter_pkg;

    // Index width for a set of n items. The result is never less than one bit,
    // so a degenerate count still gets a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snax_acc_idx_fifo.sv
// In-order queue of granted core indices. Responses are matched against its head.
module snax_acc_idx_fifo
    import snax_acc_share_arbiter_pkg::*;
#(
    parameter int Depth = 4,
    parameter int Width = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PtrW = idx_width(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW:0]    count;

    // Depth is a power of two, so both pointers wrap on their natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PtrW+1)'(1);
                2'b01:   count <= count - (PtrW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PtrW+1)'(Depth));

endmodule

// File: rtl/snax_acc_share_arbiter.sv
// Round-robin arbiter that shares one in-order accelerator port among several cores.
// Responses are steered back to cores through a queue of granted core indices.
module snax_acc_share_arbiter
    import snax_acc_share_arbiter_pkg::*;
#(
    parameter int NrCores        = 4,
    parameter int ReqWidth       = 69,
    parameter int RspWidth       = 37,
    parameter int MaxOutstanding = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NrCores-1:0]          core_q_valid_i,
    output logic [NrCores-1:0]          core_q_ready_o,
    input  logic [NrCores*ReqWidth-1:0] core_q_data_i,
    output logic [NrCores-1:0]          core_p_valid_o,
    input  logic [NrCores-1:0]          core_p_ready_i,
    output logic [RspWidth-1:0]         core_p_data_o,
    output logic                        acc_q_valid_o,
    input  logic                        acc_q_ready_i,
    output logic [ReqWidth-1:0]         acc_q_data_o,
    input  logic                        acc_p_valid_i,
    output logic                        acc_p_ready_o,
    input  logic [RspWidth-1:0]         acc_p_data_i,
    output logic                        err_o
);

    localparam int IdxW = idx_width(NrCores);

    logic [IdxW-1:0]     rr_ptr;
    logic [IdxW-1:0]     grant_idx;
    logic                grant_found;
    logic                grant_en;
    logic [ReqWidth-1:0] grant_data;
    logic                out_valid;
    logic [ReqWidth-1:0] out_data;
    logic                out_free;
    logic [IdxW-1:0]     head;
    logic                fifo_empty;
    logic                fifo_full;
    logic                rsp_pop;
    logic                err;

    // First valid core at or after rr_ptr, wrapping past the last core.
    always_comb begin
        logic [IdxW-1:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NrCores; k++) begin
            cand = IdxW'((int'(rr_ptr) + k) % NrCores);
            if (!grant_found && core_q_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // The full check deliberately ignores a same-cycle response pop.
    assign out_free = !out_valid || acc_q_ready_i;
    assign grant_en = grant_found && out_free && !fifo_full && !rst_i;

    always_comb begin
        core_q_ready_o = '0;
        grant_data     = '0;
        for (int i = 0; i < NrCores; i++) begin
            if (grant_idx == IdxW'(i)) begin
                core_q_ready_o[i] = grant_en;
                grant_data        = core_q_data_i[i*ReqWidth +: ReqWidth];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (grant_en) begin
                rr_ptr    <= (grant_idx == IdxW'(NrCores - 1)) ? '0 : grant_idx + IdxW'(1);
                out_valid <= 1'b1;
                out_data  <= grant_data;
            end else if (acc_q_ready_i) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign acc_q_valid_o = out_valid;
    assign acc_q_data_o  = out_data;

    snax_acc_idx_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) i_idx_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (grant_en),
        .push_data (grant_idx),
        .pop       (rsp_pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // With nothing outstanding the accelerator port sinks responses so it never stalls.
    assign acc_p_ready_o = rst_i || fifo_empty || core_p_ready_i[head];
    assign rsp_pop       = acc_p_valid_i && acc_p_ready_o && !fifo_empty && !rst_i;
    assign core_p_data_o = acc_p_data_i;

    always_comb begin
        core_p_valid_o = '0;
        if (!fifo_empty && !rst_i) core_p_valid_o[head] = acc_p_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else if (acc_p_valid_i && fifo_empty) begin
            err <= 1'b1;
        end
    end

    assign err_o = err;

endmodule

// File: tb/tb_snax_acc_share_arbiter.sv
// Randomized scoreboard bench for snax_acc_share_arbiter against a queue-based reference model.
module tb_snax_acc_share_arbiter;

    localparam int N  = 4;
    localparam int RW = 69;
    localparam int PW = 37;
    localparam int MO = 4;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [N-1:0]    core_q_valid_i = '0;
    logic [N-1:0]    core_q_ready_o;
    logic [N*RW-1:0] core_q_data_i = '0;
    logic [N-1:0]    core_p_valid_o;
    logic [N-1:0]    core_p_ready_i = '0;
    logic [PW-1:0]   core_p_data_o;
    logic            acc_q_valid_o;
    logic            acc_q_ready_i = 1'b0;
    logic [RW-1:0]   acc_q_data_o;
    logic            acc_p_valid_i = 1'b0;
    logic            acc_p_ready_o;
    logic [PW-1:0]   acc_p_data_i = '0;
    logic            err_o;

    always #5 clk_i = ~clk_i;

    snax_acc_share_arbiter #(
        .NrCores(N), .ReqWidth(RW), .RspWidth(PW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_q_valid_i(core_q_valid_i), .core_q_ready_o(core_q_ready_o),
        .core_q_data_i(core_q_data_i),
        .core_p_valid_o(core_p_valid_o), .core_p_ready_i(core_p_ready_i),
        .core_p_data_o(core_p_data_o),
        .acc_q_valid_o(acc_q_valid_o), .acc_q_ready_i(acc_q_ready_i),
        .acc_q_data_o(acc_q_data_o),
        .acc_p_valid_i(acc_p_valid_i), .acc_p_ready_o(acc_p_ready_o),
        .acc_p_data_i(acc_p_data_i),
        .err_o(err_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: in-flight core ids in grant order, pending send slot, rr pointer.
    int            rr = 0;
    int            outq[$];
    bit            out_busy = 0;
    bit            err_exp = 0;
    logic [RW-1:0] payload_q[$];
    int            rsp_core_q[$];

    logic [N-1:0]  v = '0;
    logic [RW-1:0] pay [N];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] rand_pay();
        return RW'({$urandom, $urandom, $urandom});
    endfunction

    task automatic drive(input bit rst, input int p_req, input int p_qrdy,
                         input int p_resp, input int p_prdy, input bit force_resp);
        int pending;
        for (int i = 0; i < N; i++) begin
            if (!v[i] && $urandom_range(99) < p_req) begin
                v[i]   = 1'b1;
                pay[i] = rand_pay();
            end
            core_q_data_i[i*RW +: RW] = pay[i];
            core_p_ready_i[i] = ($urandom_range(99) < p_prdy);
        end
        core_q_valid_i = v;
        rst_i          = rst;
        acc_q_ready_i  = rst ? 1'b0 : ($urandom_range(99) < p_qrdy);
        pending        = outq.size() - int'(out_busy);
        acc_p_valid_i  = force_resp || (pending > 0 && $urandom_range(99) < p_resp);
        acc_p_data_i   = PW'({$urandom, $urandom});
    endtask

    task automatic check_and_update();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_pv;
        logic         exp_pr;
        int           g;
        bit           free;
        bit           full;
        exp_rdy = '0;
        exp_pv  = '0;
        exp_pr  = 1'b1;
        g       = -1;
        if (!rst_i) begin
            free = !out_busy || acc_q_ready_i;
            full = outq.size() >= MO;
            if (core_q_valid_i != '0 && free && !full) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && core_q_valid_i[(rr + k) % N]) g = (rr + k) % N;
                end
                exp_rdy = N'(1) << g;
            end
            if (outq.size() != 0) begin
                exp_pv = acc_p_valid_i ? (N'(1) << outq[0]) : '0;
                exp_pr = core_p_ready_i[outq[0]];
            end
        end
        check("core_q_ready", 128'(core_q_ready_o), 128'(exp_rdy));
        check("core_p_valid", 128'(core_p_valid_o), 128'(exp_pv));
        check("acc_p_ready", 128'(acc_p_ready_o), 128'(exp_pr));
        check("core_p_data", 128'(core_p_data_o), 128'(acc_p_data_i));
        check("err", 128'(err_o), 128'(err_exp));

        if (rst_i) begin
            rr       = 0;
            out_busy = 0;
            err_exp  = 0;
            outq.delete();
            payload_q.delete();
            rsp_core_q.delete();
        end else begin
            if (acc_p_valid_i && outq.size() == 0) err_exp = 1;
            if (outq.size() != 0 && acc_p_valid_i && exp_pr) void'(outq.pop_front());
            if (g >= 0) begin
                outq.push_back(g);
                payload_q.push_back(pay[g]);
                rsp_core_q.push_back(g);
                rr       = (g + 1) % N;
                out_busy = 1;
                v[g]     = 1'b0;
            end else if (acc_q_ready_i) begin
                out_busy = 0;
            end
        end
    endtask

    task automatic run(input int n, input bit rst, input int p_req, input int p_qrdy,
                       input int p_resp, input int p_prdy, input bit force_resp);
        for (int c = 0; c < n; c++) begin
            @(posedge clk_i);
            #2;
            drive(rst, p_req, p_qrdy, p_resp, p_prdy, force_resp);
            #2;
            check_and_update();
        end
    endtask

    // Monitor: requests leaving on acc_q and responses delivered to cores.
    initial begin
        forever begin
            @(posedge clk_i);
            #3;
            check("acc_q_valid", 128'(acc_q_valid_o), 128'(payload_q.size() != 0));
            if (acc_q_valid_o && acc_q_ready_i) begin
                if (payload_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL acc_q_unexpected at %0t: got %0h expected none", $time, acc_q_data_o);
                end else begin
                    check("acc_q_data", 128'(acc_q_data_o), 128'(payload_q.pop_front()));
                end
            end
            if ((core_p_valid_o & core_p_ready_i) != '0) begin
                if (rsp_core_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL rsp_unexpected at %0t: got %0h expected none", $time, core_p_valid_o);
                end else begin
                    check("rsp_route", 128'(core_p_valid_o), 128'(N'(1) << rsp_core_q.pop_front()));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) pay[i] = '0;
        run(2,   1, 50,  50,  0,   50,  0);   // reset, with requests pending
        run(300, 0, 40,  80,  60,  80,  0);   // mixed random traffic
        run(40,  0, 100, 100, 100, 100, 0);   // saturation, round-robin fairness
        run(12,  0, 100, 100, 0,   100, 0);   // no responses: fill to the limit
        run(30,  0, 100, 70,  100, 20,  0);   // slow response consumers
        run(200, 0, 50,  60,  50,  60,  0);   // mixed random traffic
        run(20,  0, 0,   100, 100, 100, 0);   // drain
        run(1,   0, 0,   100, 0,   100, 1);   // response with nothing outstanding
        run(3,   0, 0,   100, 0,   100, 0);   // error stays set
        run(6,   0, 100, 100, 0,   100, 0);   // build up in-flight requests
        run(1,   1, 100, 100, 0,   100, 0);   // reset mid-operation
        run(3,   0, 0,   100, 0,   100, 0);
        run(1,   0, 0,   100, 0,   100, 1);   // late response after reset
        run(2,   0, 0,   100, 0,   100, 0);
        run(1,   1, 0,   100, 0,   100, 0);
        run(60,  0, 60,  70,  70,  70,  0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
